// File: rtl/dvp_sim_pkg.sv
// Shared types and constants for the DVP camera-sensor model: pattern modes, FSM states, colour bars.
package dvp_sim_pkg;

   typedef enum logic [1:0] {
      MODE_MEM  = 2'd0,
      MODE_BARS = 2'd1,
      MODE_RAMP = 2'd2,
      MODE_DIAG = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VGAP,
      S_VLEAD,
      S_LINE,
      S_HBLK,
      S_END
   } state_t;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/dvp_sim_pattern_gen.sv
// Synthetic pixel source: (mode, h, v, frame) -> RGB565 word, registered once so it lines up
// with the one-cycle latency of the external frame memory.
module dvp_sim_pattern_gen
   import dvp_sim_pkg::*;
#(
   parameter int H_ACTIVE = 160
)(
   input  logic        clk,
   input  logic        rst,
   input  mode_t       mode,
   input  logic [15:0] h,
   input  logic [15:0] v,
   input  logic [15:0] frame,
   output logic [15:0] pixel
);

   logic [2:0] bar_idx;

   // Eight equal-width bars across the active line.
   assign bar_idx = 3'((32'(h) * 32'd8) / 32'(H_ACTIVE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel <= '0;
      end else begin
         case (mode)
            MODE_BARS: pixel <= bar_colour(bar_idx);
            MODE_RAMP: pixel <= h;
            MODE_DIAG: pixel <= h + v + frame;
            default:   pixel <= '0;
         endcase
      end
   end

endmodule

// File: rtl/dvp_camera_sim.sv
// DVP camera-sensor model: frame FSM, memory/pattern pixel source and 2-cycle aligned DVP outputs.
// Define DVP_SIM_FRAME_TAG_EN to replace pixel (0,0) of every frame with the frame counter.
module dvp_camera_sim
   import dvp_sim_pkg::*;
#(
   parameter int H_ACTIVE = 160,
   parameter int V_ACTIVE = 128,
   parameter int H_BLANK  = 16,
   parameter int V_GAP    = 1000,
   parameter int V_LEAD   = 2000,
   parameter int BPP      = 2,
   parameter int FRAMES   = 64,
   parameter int ADDR_W   = 27
)(
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              ENABLE,
   input  logic [1:0]        MODE,
   output logic              PIX_RD,
   output logic [ADDR_W-1:0] PIX_ADDR,
   input  logic [15:0]       PIX_DATA,
   output logic              CAM_PCLK,
   output logic              CAM_VSYNC,
   output logic              CAM_HREF,
   output logic [7:0]        CAM_D,
   output logic [15:0]       FRAME_CNT,
   output logic              FRAME_DONE
);

   localparam int LINE_BYTES = H_ACTIVE * BPP;

   state_t      state, state_next;
   logic [31:0] cnt, cnt_next;
   logic [15:0] v, v_next;
   logic [15:0] frame_cnt;
   mode_t       mode_reg;
   logic [15:0] h;
   logic        byte_sel, in_line, first_byte, fsm_vsync, pix_rd;
   logic [15:0] pat;
   logic        s1_href, s1_vsync, s1_first, s1_sel, s1_done;
   logic [15:0] pixel_src, pixel_new, pixel_cur, pixel_keep;
   logic [7:0]  byte_out;

   always_comb begin
      state_next = state;
      cnt_next   = cnt + 32'd1;
      v_next     = v;
      case (state)
         S_IDLE: begin
            cnt_next = '0;
            v_next   = '0;
            if (ENABLE) state_next = S_VGAP;
         end
         S_VGAP:  if (cnt == 32'(V_GAP - 1))      begin state_next = S_VLEAD; cnt_next = '0; end
         S_VLEAD: if (cnt == 32'(V_LEAD - 1))     begin state_next = S_LINE;  cnt_next = '0; end
         S_LINE:  if (cnt == 32'(LINE_BYTES - 1)) begin state_next = S_HBLK;  cnt_next = '0; end
         S_HBLK: begin
            if (cnt == 32'(H_BLANK - 1)) begin
               cnt_next = '0;
               if (v == 16'(V_ACTIVE - 1)) begin
                  state_next = S_END;
               end else begin
                  state_next = S_LINE;
                  v_next     = v + 16'd1;
               end
            end
         end
         S_END: begin
            cnt_next   = '0;
            v_next     = '0;
            state_next = ENABLE ? S_VGAP : S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state     <= S_IDLE;
         cnt       <= '0;
         v         <= '0;
         frame_cnt <= '0;
         mode_reg  <= MODE_MEM;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         v     <= v_next;
         if (state == S_END) frame_cnt <= frame_cnt + 16'd1;
         // Mode only changes between frames so a frame is never mixed.
         if (state == S_VGAP && state_next == S_VLEAD) mode_reg <= mode_t'(MODE);
      end
   end

   generate
      if (BPP == 2) begin : g_two_byte
         assign h        = cnt[16:1];
         assign byte_sel = cnt[0];
      end else begin : g_one_byte
         assign h        = cnt[15:0];
         assign byte_sel = 1'b0;
      end
   endgenerate

   assign in_line    = (state == S_LINE);
   assign first_byte = in_line && !byte_sel;
   assign fsm_vsync  = (state == S_VLEAD) || (state == S_LINE) || (state == S_HBLK);
   assign pix_rd     = first_byte && (mode_reg == MODE_MEM);

   assign PIX_RD   = pix_rd;
   assign PIX_ADDR = pix_rd ? (ADDR_W'(frame_cnt & 16'(FRAMES - 1)) * ADDR_W'(H_ACTIVE * V_ACTIVE)
                               + ADDR_W'(v) * ADDR_W'(H_ACTIVE) + ADDR_W'(h))
                            : '0;

   dvp_sim_pattern_gen #(
      .H_ACTIVE (H_ACTIVE)
   ) u_pattern (
      .clk   (CLOCK),
      .rst   (RESET),
      .mode  (mode_reg),
      .h     (h),
      .v     (v),
      .frame (frame_cnt),
      .pixel (pat)
   );

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         s1_href  <= 1'b0;
         s1_vsync <= 1'b0;
         s1_first <= 1'b0;
         s1_sel   <= 1'b0;
         s1_done  <= 1'b0;
      end else begin
         s1_href  <= in_line;
         s1_vsync <= fsm_vsync;
         s1_first <= first_byte;
         s1_sel   <= byte_sel;
         s1_done  <= (state == S_END);
      end
   end

   assign pixel_src = (mode_reg == MODE_MEM) ? PIX_DATA : pat;

`ifdef DVP_SIM_FRAME_TAG_EN
   logic s1_origin;
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) s1_origin <= 1'b0;
      else       s1_origin <= first_byte && (h == 16'd0) && (v == 16'd0);
   end
   assign pixel_new = s1_origin ? frame_cnt : pixel_src;
`else
   assign pixel_new = pixel_src;
`endif

   // Memory data is only valid on the first byte; later bytes of the pixel reuse the held copy.
   assign pixel_cur = s1_first ? pixel_new : pixel_keep;
   assign byte_out  = (BPP == 2 && !s1_sel) ? pixel_cur[15:8] : pixel_cur[7:0];

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         pixel_keep <= '0;
         CAM_VSYNC  <= 1'b0;
         CAM_HREF   <= 1'b0;
         CAM_D      <= '0;
         FRAME_DONE <= 1'b0;
      end else begin
         pixel_keep <= pixel_cur;
         CAM_VSYNC  <= s1_vsync;
         CAM_HREF   <= s1_href;
         CAM_D      <= s1_href ? byte_out : 8'h00;
         FRAME_DONE <= s1_done;
      end
   end

   assign CAM_PCLK  = CLOCK;
   assign FRAME_CNT = frame_cnt;

endmodule

// File: tb/tb_dvp_camera_sim.sv
// Self-checking bench for dvp_camera_sim: captures whole frames and compares them with a
// frame-level reference built from the pixel/timing rules (BPP=2 and BPP=1 instances).
module tb_dvp_camera_sim;

   localparam int HA = 8, VA = 4, HB = 4, VG = 10, VL = 6, NF = 64, AW = 27;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, en0, en1;
   logic [1:0]    md0, md1;
   logic          rd0, rd1, pclk0, pclk1, vs0, vs1, hr0, hr1, dn0, dn1;
   logic [AW-1:0] ad0, ad1;
   logic [15:0]   pd0, pd1, fc0, fc1, salt;
   logic [7:0]    d0, d1;

   int errors = 0;
   int checks = 0;
   int which  = 0;

   dvp_camera_sim #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_GAP(VG), .V_LEAD(VL),
                    .BPP(2), .FRAMES(NF), .ADDR_W(AW)) dut (
      .CLOCK(clk), .RESET(rst), .ENABLE(en0), .MODE(md0), .PIX_RD(rd0), .PIX_ADDR(ad0),
      .PIX_DATA(pd0), .CAM_PCLK(pclk0), .CAM_VSYNC(vs0), .CAM_HREF(hr0), .CAM_D(d0),
      .FRAME_CNT(fc0), .FRAME_DONE(dn0));

   dvp_camera_sim #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_GAP(VG), .V_LEAD(VL),
                    .BPP(1), .FRAMES(NF), .ADDR_W(AW)) dut1 (
      .CLOCK(clk), .RESET(rst), .ENABLE(en1), .MODE(md1), .PIX_RD(rd1), .PIX_ADDR(ad1),
      .PIX_DATA(pd1), .CAM_PCLK(pclk1), .CAM_VSYNC(vs1), .CAM_HREF(hr1), .CAM_D(d1),
      .FRAME_CNT(fc1), .FRAME_DONE(dn1));

   // Frame memory: word = address ^ salt, returned the cycle after the read; noise otherwise.
   always @(posedge clk) begin
      pd0 <= rd0 ? (ad0[15:0] ^ salt) : 16'($urandom);
      pd1 <= rd1 ? (ad1[15:0] ^ salt) : 16'($urandom);
   end

   logic          o_vs, o_hr, o_rd, o_dn;
   logic [7:0]    o_d;
   logic [AW-1:0] o_ad;
   logic [15:0]   o_fc;
   always_comb begin
      if (which == 1) begin
         o_vs = vs1; o_hr = hr1; o_rd = rd1; o_dn = dn1; o_d = d1; o_ad = ad1; o_fc = fc1;
      end else begin
         o_vs = vs0; o_hr = hr0; o_rd = rd0; o_dn = dn0; o_d = d0; o_ad = ad0; o_fc = fc0;
      end
   end

   // Reference byte b of line v in frame f (f = frames completed before it).
   function automatic logic [7:0] exp_byte(input int mode, input int f, input int v, input int b,
                                           input int bpp);
      logic [15:0] bars [0:7];
      logic [15:0] p;
      int h;
      bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      h = b / bpp;
      case (mode)
         0:       p = 16'((f % NF) * HA * VA + v * HA + h) ^ salt;
         1:       p = bars[h * 8 / HA];
         2:       p = 16'(h);
         default: p = 16'(h + v + f);
      endcase
`ifdef DVP_SIM_FRAME_TAG_EN
      if (h == 0 && v == 0) p = 16'(f);
`endif
      if (bpp == 2 && (b % 2) == 0) return p[15:8];
      return p[7:0];
   endfunction

   int            cap_to, cap_vs_len, cap_bursts, cap_bmin, cap_bmax, cap_dbad, cap_dn_in, cap_dn_fall;
   logic [15:0]   cap_fc;
   logic [7:0]    cap_bytes [$];
   logic [AW-1:0] cap_addr [$];

   // Records one frame from VSYNC rise to fall; mid_mode is applied at the 2nd line,
   // ENABLE is dropped at line drop_line.
   task automatic capture(input logic [1:0] mid_mode, input int drop_line);
      int run;
      logic prev;
      cap_to = 0; cap_vs_len = 0; cap_bursts = 0; cap_dbad = 0; cap_dn_in = 0; cap_dn_fall = 0;
      cap_bmin = 1 << 30; cap_bmax = 0; cap_fc = '0;
      cap_bytes.delete(); cap_addr.delete();
      run = 0; prev = 1'b0;
      for (int i = 0; i < 3000 && !o_vs; i++) @(negedge clk);
      if (!o_vs) begin cap_to = 1; return; end
      for (int i = 0; i < 5000; i++) begin
         if (!o_vs) begin
            cap_dn_fall = int'(o_dn);
            cap_fc = o_fc;
            return;
         end
         cap_vs_len++;
         if (o_dn) cap_dn_in++;
         if (o_rd) cap_addr.push_back(o_ad);
         if (o_hr) begin
            cap_bytes.push_back(o_d);
            if (!prev) begin
               cap_bursts++;
               run = 0;
               if (cap_bursts == 2) begin if (which == 1) md1 = mid_mode; else md0 = mid_mode; end
               if (cap_bursts == drop_line + 1) begin if (which == 1) en1 = 1'b0; else en0 = 1'b0; end
            end
            run++;
         end else begin
            if (o_d !== 8'h00) cap_dbad++;
            if (prev) begin
               if (run < cap_bmin) cap_bmin = run;
               if (run > cap_bmax) cap_bmax = run;
            end
         end
         prev = o_hr;
         @(negedge clk);
      end
      cap_to = 1;
   endtask

   task automatic do_reset();
      en0 = 1'b0; en1 = 1'b0; rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; en0 = 1'b0; en1 = 1'b0; md0 = 2'd0; md1 = 2'd0; salt = '0; which = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({vs0, hr0, d0, rd0, ad0, fc0, dn0} !== '0) begin
         errors++; $display("FAIL reset_outputs_bpp2: got %h required 0", {vs0, hr0, d0, rd0, ad0, fc0, dn0});
      end
      checks++;
      if ({vs1, hr1, d1, rd1, ad1, fc1, dn1} !== '0) begin
         errors++; $display("FAIL reset_outputs_bpp1: got %h required 0", {vs1, hr1, d1, rd1, ad1, fc1, dn1});
      end
      @(posedge clk); #1;
      checks++;
      if (pclk0 !== 1'b1) begin errors++; $display("FAIL pclk_follows_clock: got %b required 1", pclk0); end
      @(negedge clk);
      rst = 1'b0;
      $display("reset: outputs checked");
   endtask

   task automatic test_colour_bars();
      logic [7:0] want;
      do_reset(); which = 0; md0 = 2'd1; en0 = 1'b1;
      capture(2'd1, 99);
      en0 = 1'b0;
      $display("bars frame: vsync %0d lines %0d bytes %0d", cap_vs_len, cap_bursts, cap_bytes.size());
      checks++; if (cap_to != 0) begin errors++; $display("FAIL bars_timeout: got %0d required 0", cap_to); end
      checks++; if (cap_vs_len != VL + VA * (HA * 2 + HB)) begin errors++; $display("FAIL bars_vsync_len: got %0d required %0d", cap_vs_len, VL + VA * (HA * 2 + HB)); end
      checks++; if (cap_bursts != VA) begin errors++; $display("FAIL bars_href_bursts: got %0d required %0d", cap_bursts, VA); end
      checks++; if (cap_bmin != HA * 2 || cap_bmax != HA * 2) begin errors++; $display("FAIL bars_href_len: got %0d..%0d required %0d", cap_bmin, cap_bmax, HA * 2); end
      checks++; if (cap_bytes.size() != VA * HA * 2) begin errors++; $display("FAIL bars_byte_count: got %0d required %0d", cap_bytes.size(), VA * HA * 2); end
      for (int i = 0; i < cap_bytes.size(); i++) begin
         want = exp_byte(1, 0, i / (HA * 2), i % (HA * 2), 2);
         checks++;
         if (cap_bytes[i] !== want) begin errors++; $display("FAIL bars_byte[%0d]: got %02h required %02h", i, cap_bytes[i], want); end
      end
      checks++; if (cap_dbad != 0) begin errors++; $display("FAIL bars_d_nonzero_outside_href: got %0d required 0", cap_dbad); end
      checks++; if (cap_dn_in != 0 || cap_dn_fall != 1) begin errors++; $display("FAIL bars_frame_done: got in=%0d fall=%0d required 0/1", cap_dn_in, cap_dn_fall); end
      checks++; if (cap_fc !== 16'd1) begin errors++; $display("FAIL bars_frame_cnt: got %0d required 1", cap_fc); end
      checks++; if (cap_addr.size() != 0) begin errors++; $display("FAIL bars_pix_rd: got %0d required 0", cap_addr.size()); end
   endtask

   task automatic test_memory();
      logic [7:0] want;
      do_reset(); which = 0; salt = '0; md0 = 2'd0; en0 = 1'b1;
      for (int f = 0; f < 2; f++) begin
         capture(2'd0, 99);
         $display("memory frame %0d: reads %0d bytes %0d", f, cap_addr.size(), cap_bytes.size());
         checks++; if (cap_addr.size() != HA * VA) begin errors++; $display("FAIL mem_read_count: got %0d required %0d", cap_addr.size(), HA * VA); end
         for (int i = 0; i < cap_addr.size(); i++) begin
            checks++;
            if (cap_addr[i] !== AW'(f * HA * VA + i)) begin errors++; $display("FAIL mem_addr[%0d]: got %0d required %0d", i, cap_addr[i], f * HA * VA + i); end
         end
         checks++; if (cap_bytes.size() != VA * HA * 2) begin errors++; $display("FAIL mem_byte_count: got %0d required %0d", cap_bytes.size(), VA * HA * 2); end
         for (int i = 0; i < cap_bytes.size(); i++) begin
            want = exp_byte(0, f, i / (HA * 2), i % (HA * 2), 2);
            checks++;
            if (cap_bytes[i] !== want) begin errors++; $display("FAIL mem_byte[%0d]: got %02h required %02h", i, cap_bytes[i], want); end
         end
         checks++; if (cap_fc !== 16'(f + 1)) begin errors++; $display("FAIL mem_frame_cnt: got %0d required %0d", cap_fc, f + 1); end
         if (f == 0) begin
            checks++;
            if (cap_bytes[22] !== 8'h00 || cap_bytes[23] !== 8'h0B) begin
               errors++; $display("FAIL mem_line1_pix3: got %02h,%02h required 00,0b", cap_bytes[22], cap_bytes[23]);
            end
         end
      end
      en0 = 1'b0;
   endtask

   task automatic test_random_frames();
      int m, nm, rdw;
      logic [7:0] want;
      do_reset(); which = 0; salt = 16'($urandom); m = $urandom_range(0, 3); md0 = 2'(m); en0 = 1'b1;
      for (int f = 0; f < 5; f++) begin
         nm = $urandom_range(0, 3);
         capture(2'(nm), 99);
         $display("random frame %0d: mode %0d bytes %0d reads %0d", f, m, cap_bytes.size(), cap_addr.size());
         checks++; if (cap_bytes.size() != VA * HA * 2) begin errors++; $display("FAIL rnd_byte_count: got %0d required %0d", cap_bytes.size(), VA * HA * 2); end
         for (int i = 0; i < cap_bytes.size(); i++) begin
            want = exp_byte(m, f, i / (HA * 2), i % (HA * 2), 2);
            checks++;
            if (cap_bytes[i] !== want) begin errors++; $display("FAIL rnd_f%0d_m%0d_byte[%0d]: got %02h required %02h", f, m, i, cap_bytes[i], want); end
         end
         rdw = (m == 0) ? HA * VA : 0;
         checks++; if (cap_addr.size() != rdw) begin errors++; $display("FAIL rnd_read_count: got %0d required %0d", cap_addr.size(), rdw); end
         checks++; if (cap_fc !== 16'(f + 1)) begin errors++; $display("FAIL rnd_frame_cnt: got %0d required %0d", cap_fc, f + 1); end
         m = nm;
      end
      en0 = 1'b0;
   endtask

   task automatic test_enable_drop();
      int vs_seen, dn_seen;
      do_reset(); which = 0; md0 = 2'($urandom_range(1, 3)); en0 = 1'b1;
      capture(md0, 2);
      $display("enable drop: bytes %0d frame_cnt %0d", cap_bytes.size(), cap_fc);
      checks++; if (cap_bytes.size() != VA * HA * 2) begin errors++; $display("FAIL drop_frame_complete: got %0d required %0d", cap_bytes.size(), VA * HA * 2); end
      checks++; if (cap_dn_fall != 1 || cap_dn_in != 0) begin errors++; $display("FAIL drop_frame_done: got fall=%0d in=%0d required 1/0", cap_dn_fall, cap_dn_in); end
      vs_seen = 0; dn_seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (vs0 || hr0) vs_seen++;
         if (dn0) dn_seen++;
      end
      checks++; if (vs_seen != 0) begin errors++; $display("FAIL drop_no_new_frame: got %0d active cycles required 0", vs_seen); end
      checks++; if (dn_seen != 0) begin errors++; $display("FAIL drop_extra_done: got %0d required 0", dn_seen); end
      checks++; if (fc0 !== 16'd1) begin errors++; $display("FAIL drop_frame_cnt: got %0d required 1", fc0); end
   endtask

   task automatic test_reset_mid_line();
      int n;
      do_reset(); which = 0; md0 = 2'd2; en0 = 1'b1;
      capture(2'd2, 99);
      n = 0;
      while (!hr0 && n < 500) begin @(negedge clk); n++; end
      checks++; if (hr0 !== 1'b1) begin errors++; $display("FAIL rstmid_href_wait: got %b required 1", hr0); end
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({vs0, hr0, d0, rd0, ad0, fc0, dn0} !== '0) begin
         errors++; $display("FAIL rstmid_outputs: got %h required 0", {vs0, hr0, d0, rd0, ad0, fc0, dn0});
      end
      @(negedge clk);
      rst = 1'b0;
      // One IDLE cycle, V_GAP gap cycles, then the 2-cycle output latency.
      n = 0;
      while (!vs0 && n < 100) begin @(negedge clk); n++; end
      $display("reset mid-line: vsync rose after %0d cycles", n);
      checks++; if (n != VG + 3) begin errors++; $display("FAIL rstmid_vsync_delay: got %0d required %0d", n, VG + 3); end
      en0 = 1'b0;
   endtask

   task automatic test_bpp1();
      logic [7:0] want;
      do_reset(); which = 1; md1 = 2'd2; en1 = 1'b1;
      capture(2'd3, 99);
      $display("bpp1 frame 0: vsync %0d bytes %0d", cap_vs_len, cap_bytes.size());
      checks++; if (cap_vs_len != VL + VA * (HA + HB)) begin errors++; $display("FAIL bpp1_vsync_len: got %0d required %0d", cap_vs_len, VL + VA * (HA + HB)); end
      checks++; if (cap_bmin != HA || cap_bmax != HA) begin errors++; $display("FAIL bpp1_href_len: got %0d..%0d required %0d", cap_bmin, cap_bmax, HA); end
      checks++; if (cap_bytes.size() != VA * HA) begin errors++; $display("FAIL bpp1_byte_count: got %0d required %0d", cap_bytes.size(), VA * HA); end
      for (int i = 0; i < cap_bytes.size(); i++) begin
         want = exp_byte(2, 0, i / HA, i % HA, 1);
         checks++;
         if (cap_bytes[i] !== want) begin errors++; $display("FAIL bpp1_ramp_byte[%0d]: got %02h required %02h", i, cap_bytes[i], want); end
      end
      capture(2'd3, 99);
      $display("bpp1 frame 1: bytes %0d", cap_bytes.size());
      checks++; if (cap_bytes.size() != VA * HA) begin errors++; $display("FAIL bpp1_f1_byte_count: got %0d required %0d", cap_bytes.size(), VA * HA); end
      for (int i = 0; i < cap_bytes.size(); i++) begin
         want = exp_byte(3, 1, i / HA, i % HA, 1);
         checks++;
         if (cap_bytes[i] !== want) begin errors++; $display("FAIL bpp1_diag_byte[%0d]: got %02h required %02h", i, cap_bytes[i], want); end
      end
      checks++; if (cap_fc !== 16'd2) begin errors++; $display("FAIL bpp1_frame_cnt: got %0d required 2", cap_fc); end
      en1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_colour_bars();
      test_memory();
      test_random_frames();
      test_enable_drop();
      test_reset_mid_line();
      test_bpp1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
